// File: rtl/conv_rr_arbiter32.sv
// Round-robin arbiter for 32 requesters sharing one resource, with registered
// grant index/one-hot outputs and an optional hold-time watchdog.
module conv_rr_arbiter32 #(
    parameter int MAX_HOLD = 16,
    parameter bit TO_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req,
    input  logic        done,
    output logic        gnt_valid,
    output logic [4:0]  gnt_idx,
    output logic [31:0] gnt_onehot,
    output logic        timeout,
    output logic [4:0]  to_idx,
    output logic        busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state, state_nx;
    logic [1:0]  rst_sync;
    logic [4:0]  ptr, ptr_nx, idx_nx, to_idx_nx, base, off, win_idx;
    logic [8:0]  hold, hold_nx;
    logic [31:0] rot;
    logic        win_vld, rel_done, forced, timeout_nx;

    // Reset assertion is immediate; release is delayed two edges so no
    // state register sees a partial first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    // Search base: after a release the holder's successor, otherwise ptr.
    always_comb begin
        base = (state == GRANT) ? gnt_idx + 5'd1 : ptr;
        rot  = (req >> base) | (req << (6'd32 - {1'b0, base}));
        off  = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (rot[i]) off = 5'(i);
        end
        win_vld = |req;
        win_idx = base + off;
    end

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        idx_nx     = gnt_idx;
        hold_nx    = hold;
        timeout_nx = 1'b0;
        to_idx_nx  = to_idx;
        rel_done   = done || !req[gnt_idx];
        forced     = TO_EN && (hold == 9'(MAX_HOLD - 1)) && !rel_done;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nx = GRANT;
                    idx_nx   = win_idx;
                    hold_nx  = 9'd0;
                end
            end
            GRANT: begin
                if (rel_done || forced) begin
                    ptr_nx  = gnt_idx + 5'd1;
                    hold_nx = 9'd0;
                    if (forced) begin
                        timeout_nx = 1'b1;
                        to_idx_nx  = gnt_idx;
                    end
                    if (win_vld) idx_nx   = win_idx;
                    else         state_nx = IDLE;
                end else if (TO_EN) begin
                    hold_nx = hold + 9'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 5'd0;
            hold       <= 9'd0;
            gnt_idx    <= 5'd0;
            gnt_onehot <= 32'd0;
            timeout    <= 1'b0;
            to_idx     <= 5'd0;
        end else if (rst_sync[1]) begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            hold       <= hold_nx;
            gnt_idx    <= idx_nx;
            gnt_onehot <= (state_nx == GRANT) ? (32'd1 << idx_nx) : 32'd0;
            timeout    <= timeout_nx;
            to_idx     <= to_idx_nx;
        end
    end

    assign gnt_valid = (state == GRANT);
    assign busy      = gnt_valid;

endmodule

// File: tb/tb_conv_rr_arbiter32.sv
// Bench for conv_rr_arbiter32: directed scenarios plus random traffic, all
// outputs checked every cycle against a queue-free behavioural model.
module tb_conv_rr_arbiter32;

    localparam int MAX_HOLD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req = 32'd0;
    logic        done = 1'b0;
    logic        gnt_valid, timeout, busy;
    logic [4:0]  gnt_idx, to_idx;
    logic [31:0] gnt_onehot;

    int errs = 0;
    int checks = 0;

    conv_rr_arbiter32 #(.MAX_HOLD(MAX_HOLD), .TO_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot),
        .timeout(timeout), .to_idx(to_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: m_held counts visible grant cycles so far.
    bit m_valid, m_to;
    int m_idx, m_ptr, m_held, m_sync, m_to_idx;

    function automatic int find(input logic [31:0] r, input int b);
        for (int k = 0; k < 32; k++)
            if (r[(b + k) % 32]) return (b + k) % 32;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        bit rel, frc;
        if (!rst_n) begin
            m_valid = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_held = 0;
            m_sync = 0; m_to_idx = 0;
        end else if (m_sync < 2) begin
            m_sync++;
        end else begin
            m_to = 0;
            if (!m_valid) begin
                w = find(req, m_ptr);
                if (w >= 0) begin m_valid = 1; m_idx = w; m_held = 1; end
            end else begin
                rel = done || !req[m_idx];
                frc = !rel && (m_held == MAX_HOLD);
                if (rel || frc) begin
                    m_ptr = (m_idx + 1) % 32;
                    if (frc) begin m_to = 1; m_to_idx = m_idx; end
                    w = find(req, m_ptr);
                    if (w >= 0) begin m_idx = w; m_held = 1; end
                    else m_valid = 0;
                end else begin
                    m_held++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            chk("valid", 32'(gnt_valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(m_valid));
            chk("onehot", gnt_onehot, m_valid ? (32'd1 << m_idx) : 32'd0);
            if (m_valid) chk("idx", 32'(gnt_idx), 32'(m_idx));
            chk("timeout", 32'(timeout), 32'(m_to));
            if (m_to) chk("to_idx", 32'(to_idx), 32'(m_to_idx));
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idx"}, 32'(gnt_idx), 32'd0);
        chk({tag, "_onehot"}, gnt_onehot, 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_to_idx"}, 32'(to_idx), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single requester, then done with request dropped
        req = 32'h1;
        @(negedge clk);
        chk("t1_valid", 32'(gnt_valid), 32'd1);
        chk("t1_idx", 32'(gnt_idx), 32'd0);
        chk("t1_onehot", gnt_onehot, 32'h1);
        repeat (2) @(negedge clk);
        done = 1'b1; req = 32'h0;
        @(negedge clk);
        done = 1'b0;
        chk("t1_release", 32'(gnt_valid), 32'd0);
        req = 32'h3;
        @(negedge clk);
        chk("t1_ptr1", 32'(gnt_idx), 32'd1);
        req = 32'h0;
        @(negedge clk);

        // all requesting, done every cycle: strict rotation without bubbles
        req = 32'hFFFF_FFFF; done = 1'b1;
        @(negedge clk);
        chk("t2_first", 32'(gnt_idx), 32'd2);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            chk("t2_valid", 32'(gnt_valid), 32'd1);
            chk("t2_seq", 32'(gnt_idx), 32'((2 + k) % 32));
        end
        req = 32'h0; done = 1'b0;
        @(negedge clk);

        // wrap-around from ptr=31
        req = 32'h4000_0000;
        @(negedge clk);
        chk("t3_g30", 32'(gnt_idx), 32'd30);
        req = 32'h0;
        @(negedge clk);
        req = 32'h8000_0001;
        @(negedge clk);
        chk("t3_g31", 32'(gnt_idx), 32'd31);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("t3_g0", 32'(gnt_idx), 32'd0);
        req = 32'h0;
        @(negedge clk);

        // watchdog: two forced releases alternating 4 and 5
        req = 32'h30;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (timeout) break;
            if (gnt_valid && gnt_idx == 5'd4) n++;
        end
        chk("t4_hold4", 32'(n), 32'd16);
        chk("t4_to1", 32'(timeout), 32'd1);
        chk("t4_toidx4", 32'(to_idx), 32'd4);
        chk("t4_g5", 32'(gnt_idx), 32'd5);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (timeout) break;
            if (gnt_valid && gnt_idx == 5'd5) n++;
        end
        chk("t4_hold5", 32'(n), 32'd16);
        chk("t4_to2", 32'(timeout), 32'd1);
        chk("t4_toidx5", 32'(to_idx), 32'd5);
        chk("t4_g4", 32'(gnt_idx), 32'd4);

        // done on the final allowed cycle: normal release, no pulse
        repeat (15) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("t5_noto", 32'(timeout), 32'd0);
        chk("t5_g5", 32'(gnt_idx), 32'd5);
        req = 32'h0;
        @(negedge clk);

        // asynchronous reset mid-grant
        req = 32'h200;
        @(negedge clk);
        chk("t6_g9", 32'(gnt_idx), 32'd9);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("arst");
        req = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        req = 32'h200;
        @(negedge clk);
        chk("t6_valid", 32'(gnt_valid), 32'd1);
        chk("t6_regrant9", 32'(gnt_idx), 32'd9);

        // random traffic, checked by the model every cycle
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: req = 32'h0;
                    1: req = $urandom;
                    2: req = $urandom & $urandom & $urandom;
                    default: req = 32'd1 << $urandom_range(31);
                endcase
            end
            done = ($urandom_range(9) == 0);
        end
        done = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
